// File: rtl/mem_pkg.sv
// mem_pkg: size/state encodings and little-endian lane merge/extract helpers
package mem_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_BUSY = 2'b01, S_RESP = 2'b10} state_t;
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                             input size_t size, input logic [1:0] lane);
    logic [31:0] w;
    w = old_word;
    if (size == SZ_BYTE) w[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (size == SZ_HALF) w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    else if (size == SZ_WORD) w = wdata;
    return w;
  endfunction
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input size_t size, input logic [1:0] lane);
    return size == SZ_BYTE ? {24'b0, word[{lane, 3'b000} +: 8]} :
           size == SZ_HALF ? {16'b0, word[{lane[1], 4'b0000} +: 16]} :
           size == SZ_WORD ? word : 32'b0;
  endfunction
endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: combinational byte-lane merge for writes and zero-extended extract for reads
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  size_t       size,
  input  logic [1:0]  lane,
  output logic [31:0] merged,
  output logic [31:0] extracted
);
  assign merged = lane_merge(old_word, wdata, size, lane);
  assign extracted = lane_extract(old_word, size, lane);
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding req/ack memory responder with LATENCY wait states
// Optional MISALIGN_CHECK_EN turns misaligned half/word accesses into faults.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic c_we;
  logic [31:0] c_addr, c_wdata;
  size_t c_size;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] merged, extracted;
  logic misalign, bad, resp;
  logic [AW-1:0] idx;
`ifdef MISALIGN_CHECK_EN
  assign misalign = (c_size == SZ_HALF && c_addr[0]) || (c_size == SZ_WORD && c_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign bad = c_addr >= 32'(DEPTH_WORDS * 4) || c_size == SZ_RSVD || misalign;
  assign idx = c_addr[AW+1:2];
  // a reset in the RESP cycle abandons the transaction, so it also hides the ack
  assign resp = state == S_RESP && !reset;
  assign ack = resp;
  assign fault = resp && bad;
  assign rdata = resp && !bad ? extracted : 32'b0;
  assign busy = state != S_IDLE;
  mem_lane_unit u_lane (
    .old_word (mem[idx]),
    .wdata    (c_wdata),
    .size     (c_size),
    .lane     (c_addr[1:0]),
    .merged   (merged),
    .extracted(extracted)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == S_IDLE && req) begin
      state_n = LATENCY == 1 ? S_RESP : S_BUSY;
      cnt_n = 4'(LATENCY - 1);
    end else if (state == S_BUSY) begin
      cnt_n = cnt - 4'd1;
      state_n = cnt_n == 4'd0 ? S_RESP : S_BUSY;
    end else if (state == S_RESP) state_n = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
    if (state == S_IDLE && req) begin
      c_we <= we;
      c_addr <= addr;
      c_size <= size_t'(size);
      c_wdata <= wdata;
    end
  end
  always_ff @(posedge clk)
    if (resp && c_we && !bad) mem[idx] <= merged;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of handshake, lanes, faults, latency and reset abort
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset, req, we;
  logic [31:0] addr, wdata;
  logic [1:0] size;
  logic ack, fault, busy;
  logic [31:0] rdata;
  logic req1, we1;
  logic [31:0] addr1, wdata1;
  logic [1:0] size1;
  logic ack1, fault1, busy1;
  logic [31:0] rdata1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .size(size), .wdata(wdata),
    .ack(ack), .rdata(rdata), .fault(fault), .busy(busy)
  );
  mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .size(size1), .wdata(wdata1),
    .ack(ack1), .rdata(rdata1), .fault(fault1), .busy(busy1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic xact(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output logic f, output int lat);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; size = s; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    while (!ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    f = fault;
    @(posedge clk); #1;
  endtask
  logic [31:0] rd;
  logic f;
  int lat;
  logic [11:0] mask;
  int n;
  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; size = '0; wdata = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; size1 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, ack}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_fault", {31'b0, fault}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    reset = 1'b0;
    xact(1, 32'h10, 2'b10, 32'hDEADBEEF, rd, f, lat);
    check("wr_word_lat", lat, 2);
    check("wr_word_fault", {31'b0, f}, 0);
    xact(0, 32'h10, 2'b10, 0, rd, f, lat);
    check("rd_word", rd, 32'hDEADBEEF);
    check("rd_word_lat", lat, 2);
    xact(1, 32'h11, 2'b00, 32'hFFFFFF5A, rd, f, lat);
    xact(1, 32'h12, 2'b01, 32'hFFFF1234, rd, f, lat);
    xact(0, 32'h10, 2'b10, 0, rd, f, lat);
    check("rd_merged", rd, 32'h12345AEF);
    xact(0, 32'h13, 2'b00, 0, rd, f, lat);
    check("rd_byte13", rd, 32'h00000012);
    xact(0, 32'h10, 2'b00, 0, rd, f, lat);
    check("rd_byte10", rd, 32'h000000EF);
    xact(0, 32'h12, 2'b01, 0, rd, f, lat);
    check("rd_half12", rd, 32'h00001234);
    xact(1, 32'h0, 2'b10, 32'h11223344, rd, f, lat);
    xact(1, 32'hFC, 2'b10, 32'h55667788, rd, f, lat);
    xact(0, 32'hFC, 2'b10, 0, rd, f, lat);
    check("rd_last_word", rd, 32'h55667788);
    check("rd_last_fault", {31'b0, f}, 0);
    xact(0, 32'h100, 2'b10, 0, rd, f, lat);
    check("range_fault", {31'b0, f}, 1);
    check("range_rdata", rd, 0);
    xact(1, 32'h100, 2'b10, 32'h0BAD0BAD, rd, f, lat);
    check("range_wr_fault", {31'b0, f}, 1);
    xact(1, 32'h0, 2'b11, 32'hFFFFFFFF, rd, f, lat);
    check("rsvd_fault", {31'b0, f}, 1);
    check("rsvd_rdata", rd, 0);
    xact(0, 32'h0, 2'b10, 0, rd, f, lat);
    check("word0_kept", rd, 32'h11223344);
    // req held high: acks every LATENCY+1 cycles
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; size = 2'b10;
    mask = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      mask[i] = ack;
    end
    @(negedge clk);
    req = 1'b0;
    check("held_req_acks", {20'b0, mask}, 32'h492);
    @(posedge clk); #1;
    // extra req pulse during BUSY
    @(negedge clk);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check("pulse_busy", {31'b0, busy}, 1);
    @(negedge clk);
    req = 1'b1;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      req = 1'b0;
      n += int'(ack);
    end
    check("pulse_one_ack", n, 1);
    // LATENCY=1 instance
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h4; size1 = 2'b10; wdata1 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req1 = 1'b0;
    check("l1_ack", {31'b0, ack1}, 1);
    check("l1_busy", {31'b0, busy1}, 1);
    @(posedge clk); #1;
    check("l1_ack_drop", {31'b0, ack1}, 0);
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0;
    @(posedge clk); #1;
    req1 = 1'b0;
    check("l1_rd_ack", {31'b0, ack1}, 1);
    check("l1_rd", rdata1, 32'hA5A5A5A5);
    // reset in BUSY abandons the write
    xact(1, 32'h20, 2'b10, 32'h01020304, rd, f, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; size = 2'b10; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req = 1'b0;
    check("abort_busy", {31'b0, busy}, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_ack", {31'b0, ack}, 0);
    check("abort_busy_clr", {31'b0, busy}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_no_ack", {31'b0, ack}, 0);
    xact(0, 32'h20, 2'b10, 0, rd, f, lat);
    check("abort_kept", rd, 32'h01020304);
    // misaligned word and half reads
    xact(0, 32'h12, 2'b10, 0, rd, f, lat);
`ifdef MISALIGN_CHECK_EN
    check("misalign_word_fault", {31'b0, f}, 1);
    check("misalign_word_rdata", rd, 0);
`else
    check("misalign_word_fault", {31'b0, f}, 0);
    check("misalign_word_rdata", rd, 32'h12345AEF);
`endif
    xact(0, 32'h13, 2'b01, 0, rd, f, lat);
`ifdef MISALIGN_CHECK_EN
    check("misalign_half_fault", {31'b0, f}, 1);
    check("misalign_half_rdata", rd, 0);
`else
    check("misalign_half_fault", {31'b0, f}, 0);
    check("misalign_half_rdata", rd, 32'h00001234);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's data/instruction port.
- Accepts one CPU-initiated read or write request at a time over a req/ack handshake, with configurable wait-state latency.
- Supports byte, halfword and word accesses to an internal word array, little-endian byte lanes.
- Flags out-of-range accesses to the control unit's exception path via `fault`.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; byte address range is 0 .. DEPTH_WORDS*4-1.
- LATENCY, 2, cycles from request acceptance to ack; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; captured with req.
- addr  in  32  byte address; captured with req.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as fault); captured with req.
- wdata  in  32  write data, right-justified (byte in [7:0], half in [15:0]); captured with req.
- ack  out  1  one-cycle completion pulse.
- rdata  out  32  read data, zero-extended, right-justified; valid only while ack=1, else 0.
- fault  out  1  asserted with ack when the request was rejected.
- busy  out  1  high from the cycle after acceptance through the ack cycle.

Behaviour:
- Reset: one clock, synchronous, active-high. On reset, state=IDLE, ack=0, rdata=0, fault=0, busy=0, counter=0. Memory array contents are not cleared. Reset during BUSY or RESP abandons the transaction: no ack, no write commit.
- States:
  - IDLE: req=1 captures we/addr/size/wdata, loads counter with LATENCY-1, and goes to BUSY (LATENCY>1) or RESP (LATENCY=1).
  - BUSY: counter decrements each cycle; at 0, go to RESP. req is ignored.
  - RESP: ack=1 for exactly one cycle, then go to IDLE. req in the RESP cycle is ignored; the next acceptance is possible at the earliest in the following IDLE cycle.
- Latency: ack is asserted exactly LATENCY cycles after the acceptance edge. Back-to-back requests are spaced LATENCY+1 cycles.
- Fault conditions (evaluated on captured fields): addr >= DEPTH_WORDS*4, or size=11. On fault: ack=1, fault=1, rdata=0, no write.
- Write commit: happens on the RESP edge, only if no fault. Lanes:
  - byte: lane addr[1:0] ← wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} ← wdata[15:0].
  - word: all lanes ← wdata.
  - Untouched lanes are preserved.
- Read: word index addr[31:2]; byte/half extracted from the addressed lane(s) and zero-extended. Sign extension is the CPU's job.
- Misaligned access with MISALIGN_CHECK_EN undefined: low address bits are forced (half uses addr[1], word ignores addr[1:0]); no fault.
- Read in the same cycle as a commit is not possible, since only one transaction is in flight.
- Word index computed as addr[log2(DEPTH_WORDS)+1:2] after the range check; no wrap-around.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=00, produces fault=1 with ack, rdata=0, no write. These faults take the same priority as the range fault.
- Undefined: alignment bits are silently forced as described above; fault only on range or size=11.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - state encoding S_IDLE/S_BUSY/S_RESP.
  - lane-merge function (old word, wdata, size, addr[1:0]) → new word.
  - lane-extract function → zero-extended rdata.
- One sub-module is natural: mem_lane_unit, combinational merge/extract, so the verifier can unit-test lane logic separately. The FSM, counter and array stay in mem_responder.

Test Plan:
- Reset then word write (LATENCY=2): req with we=1, addr=0x10, size=10, wdata=0xDEADBEEF → ack 2 cycles after acceptance, fault=0. A following word read of 0x10 → rdata=0xDEADBEEF with ack.
- Byte/half lanes: write byte 0x5A to 0x11, then half 0x1234 to 0x12 → word read of 0x10 returns 0x12345AEF. Byte read of 0x13 returns 0x00000012.
- Range and size faults: read addr=0x100 (DEPTH_WORDS=64), then write size=11 to 0x0 → each gets ack=1, fault=1, rdata=0. Word at 0x0 is unchanged.
- Handshake: req held high continuously → acceptances every LATENCY+1 cycles. A req pulse during BUSY gets no extra ack. With LATENCY=1, ack arrives on the next cycle.
- Reset mid-op: accept a word write of 0xCAFEF00D to 0x20, assert reset in BUSY → no ack; busy=0 next cycle; word at 0x20 keeps its old value.
- MISALIGN_CHECK_EN: with the macro defined, word read at 0x12 → fault=1. With it undefined, the same request returns the word at 0x10 with fault=0.
